// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared types and constants for the data-memory controller:
//            FSM state encoding, word width, byte-offset width and a helper
//            that sizes the latency counter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int WORD_W   = 32;
  localparam int ADDR_LSB = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter must hold LATENCY-1; a one-cycle latency still needs one bit.
  function automatic int cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage : mem_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Purpose  : DEPTH x 32 word storage with one synchronous write port and a
//            read port sampled on the same edge (old data on a same-address
//            write). The read register clears on reset and only updates on
//            a read strobe, so it doubles as the held load result.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clock_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clock_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read sample; non-blocking semantics give pre-write data on a collision.
  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_ctrl
// Purpose  : Multi-cycle data-memory controller for the load/store path.
//            Accepts an aligned load/store in IDLE, spends LATENCY cycles in
//            BUSY (committing on the last one), then one DONE cycle so the
//            core can retire the instruction without re-triggering.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [WORD_W-1:0] address,
  input  logic [WORD_W-1:0] writedata,
  output logic [WORD_W-1:0] readdata,
  output logic              stall,
  output logic              misaligned
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;

  logic req;
  logic aligned;
  logic ok;
  logic commit;

  assign req     = memread | memwrite;
  assign aligned = (address[ADDR_LSB-1:0] == '0);
  assign ok      = req & aligned;
  assign commit  = (state_q == ST_BUSY) && (cnt_q == '0);

  // Upper address bits fall outside the array and wrap by design.
  if (ADDR_LSB + AW < WORD_W) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^address[WORD_W-1:ADDR_LSB+AW];
  end else begin : g_addr_full
  end

  // State, counter and captured request registers.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  // Next-state: accept aligned requests in IDLE, count down in BUSY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ok) begin
          idx_d   = address[ADDR_LSB +: AW];
          wdata_d = writedata;
          rd_d    = memread;
          wr_d    = memwrite;
          cnt_d   = CNT_LOAD;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are forced low while reset is held so the core is not frozen.
  assign stall      = Reset & (((state_q == ST_IDLE) & ok) | (state_q == ST_BUSY));
  assign misaligned = Reset & (state_q == ST_IDLE) & req & ~aligned;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clock_i (clock),
    .rst_ni  (Reset),
    .we_i    (commit & wr_q),
    .re_i    (commit & rd_q),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (readdata)
  );

endmodule : dmem_ctrl
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_ctrl
// Purpose  : Self-checking bench for dmem_ctrl: directed vector table,
//            reset corner cases and randomized accesses against a word-array
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;

  localparam int TB_DEPTH = 256;
  localparam int TB_LAT   = 2;

  logic        clock;
  logic        Reset;
  logic        memread;
  logic        memwrite;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        stall;
  logic        misaligned;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem_m [TB_DEPTH];
  bit          known [TB_DEPTH];
  logic [31:0] last_rd;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_mis;
  } vec_t;

  vec_t tbl [9];

  dmem_ctrl #(
    .DEPTH   (TB_DEPTH),
    .LATENCY (TB_LAT)
  ) dut (
    .clock      (clock),
    .Reset      (Reset),
    .memread    (memread),
    .memwrite   (memwrite),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .stall      (stall),
    .misaligned (misaligned)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Reference behaviour: word array indexed modulo DEPTH, load returns pre-write data.
  task automatic model_apply(input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wd, output logic [31:0] exp);
    int idx;
    idx = int'((addr / 4) % TB_DEPTH);
    if (rd) last_rd = mem_m[idx];
    if (wr) begin
      mem_m[idx] = wd;
      known[idx] = 1'b1;
    end
    exp = last_rd;
  endtask

  // Aligned access: stall for LATENCY+1 cycles, data valid in the DONE cycle.
  task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp_rd);
    @(posedge clock); #1;
    memread = rd; memwrite = wr; address = addr; writedata = wd;
    @(negedge clock);
    check("stall_first_cycle", {31'd0, stall}, 32'd1);
    for (int c = 1; c <= TB_LAT; c++) begin
      @(posedge clock); #1;
      address = $urandom & 32'hFFFF_FFFC; writedata = $urandom;
      @(negedge clock);
      check("stall_busy", {31'd0, stall}, 32'd1);
    end
    @(posedge clock); #1;
    address = $urandom & 32'hFFFF_FFFC; writedata = $urandom;
    @(negedge clock);
    check("stall_done", {31'd0, stall}, 32'd0);
    check("misaligned_done", {31'd0, misaligned}, 32'd0);
    check("readdata_done", readdata, exp_rd);
  endtask

  // Misaligned request held two cycles: flagged, no stall, FSM stays IDLE.
  task automatic do_mis(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] exp_rd);
    @(posedge clock); #1;
    memread = rd; memwrite = wr; address = addr; writedata = $urandom;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      check("misaligned_flag", {31'd0, misaligned}, 32'd1);
      check("misaligned_stall", {31'd0, stall}, 32'd0);
      check("misaligned_rdata", readdata, exp_rd);
      if (c == 0) begin
        @(posedge clock); #1;
      end
    end
  endtask

  task automatic idle();
    @(posedge clock); #1;
    memread = 1'b0; memwrite = 1'b0;
    @(negedge clock);
    check("idle_stall", {31'd0, stall}, 32'd0);
    check("idle_hold", readdata, last_rd);
  endtask

  initial begin
    logic [31:0] exp;
    logic [31:0] a;
    logic [31:0] d;
    bit rd;
    bit wr;
    int r;

    tbl[0] = '{1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 32'h0000_0400, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h1234_5678, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 32'h0000_0041, 32'h0000_0000, 32'h1234_5678, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 32'h0000_0010, 32'h0000_000A, 32'h1234_5678, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 32'h0000_0010, 32'h0000_000B, 32'h0000_000A, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h0000_000B, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0000_0011, 32'h0000_000B, 1'b0};

    for (int i = 0; i < TB_DEPTH; i++) known[i] = 1'b0;
    last_rd = 32'd0;

    // Reset held with a pending read request.
    Reset = 1'b0; memread = 1'b1; memwrite = 1'b0; address = 32'd0; writedata = 32'd0;
    repeat (3) @(negedge clock);
    check("reset_readdata", readdata, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_misaligned", {31'd0, misaligned}, 32'd0);
    @(posedge clock); #1;
    address = 32'h0000_0041;
    @(negedge clock);
    check("reset_misaligned_addr", {31'd0, misaligned}, 32'd0);
    @(posedge clock); #1;
    Reset = 1'b1; memread = 1'b0; address = 32'd0;

    // Directed vector table; odd entries run back-to-back with the next.
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].exp_mis) begin
        do_mis(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].exp_rdata);
        idle();
      end else begin
        model_apply(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, exp);
        do_access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata);
        if (i % 2 == 0) idle();
      end
    end
    idle();

    // Reset pulsed in the first BUSY cycle of a store 0x55 @0x20.
    @(posedge clock); #1;
    memread = 1'b0; memwrite = 1'b1; address = 32'h0000_0020; writedata = 32'h0000_0055;
    @(negedge clock);
    check("abort_stall_c0", {31'd0, stall}, 32'd1);
    @(posedge clock); #1;
    Reset = 1'b0;
    @(negedge clock);
    check("abort_stall", {31'd0, stall}, 32'd0);
    check("abort_readdata", readdata, 32'd0);
    @(posedge clock); #1;
    Reset = 1'b1; memwrite = 1'b0;
    last_rd = 32'd0;
    model_apply(1'b1, 1'b0, 32'h0000_0020, 32'd0, exp);
    do_access(1'b1, 1'b0, 32'h0000_0020, 32'd0, exp);
    check("abort_store_dropped", exp, 32'h0000_0011);
    idle();

    // Randomized accesses over 16 word slots with random upper (wrapping) bits.
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 9));
      a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
      d = $urandom;
      if (r == 0) begin
        a[1:0] = 2'($urandom_range(1, 3));
        rd = 1'($urandom_range(0, 1));
        wr = ~rd | 1'($urandom_range(0, 1));
        do_mis(rd, wr, a, last_rd);
        idle();
      end else begin
        rd = (r <= 4) || (r >= 8);
        wr = (r >= 5);
        if (rd && !known[int'((a / 4) % TB_DEPTH)]) begin
          rd = 1'b0;
          wr = 1'b1;
        end
        model_apply(rd, wr, a, d, exp);
        do_access(rd, wr, a, d, exp);
        if ($urandom_range(0, 1) == 1) idle();
      end
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_dmem_ctrl
`default_nettype wire
